// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: system memory map,
// slave indices, decode tables and the arbiter state encoding.
package periph_bus_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned NUM_SLV = 5;
  localparam int unsigned IDX_W   = 3;

  localparam int unsigned SLV_ROM   = 0;
  localparam int unsigned SLV_SPI   = 1;
  localparam int unsigned SLV_UART  = 2;
  localparam int unsigned SLV_CLINT = 3;
  localparam int unsigned SLV_RAM   = 4;

  localparam logic [31:0] ROM_BASE     = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK     = 32'h0000_007F;
  localparam logic [31:0] SPI_BASE     = 32'h0010_0000;
  localparam logic [31:0] SPI_MASK     = 32'h000F_FFFF;
  localparam logic [31:0] UART_TX_BASE = 32'h0100_0000;
  localparam logic [31:0] UART_RX_BASE = 32'h0100_0010;
  localparam logic [31:0] CLINT_BASE   = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK   = 32'h0000_FFFF;
  localparam logic [31:0] RAM_BASE     = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK     = 32'h000F_FFFF;

  // uart tx and rx share one select; the merged window spans both 16-byte blocks
  localparam logic [31:0] UART_BASE = UART_TX_BASE;
  localparam logic [31:0] UART_MASK = (UART_RX_BASE - UART_TX_BASE) * 2 - 1;

  localparam logic [NUM_SLV-1:0][31:0] SLV_BASE =
    {RAM_BASE, CLINT_BASE, UART_BASE, SPI_BASE, ROM_BASE};
  localparam logic [NUM_SLV-1:0][31:0] SLV_MASK =
    {RAM_MASK, CLINT_MASK, UART_MASK, SPI_MASK, ROM_MASK};

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational memory-map decoder: one-hot slave hit (lowest index wins)
// plus an unmapped flag when no window matches.
module periph_addr_decode
  import periph_bus_arbiter_pkg::*;
(
  input  logic [31:0]        addr,
  output logic [NUM_SLV-1:0] hit,
  output logic               unmapped
);

  always_comb begin
    hit      = '0;
    unmapped = 1'b1;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (unmapped && ((addr & ~SLV_MASK[k]) == SLV_BASE[k])) begin
        hit[k]   = 1'b1;
        unmapped = 1'b0;
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter for the uncached peripheral bus with
// address decode, single outstanding access, and unmapped/timeout errors.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int unsigned num_req        = NUM_REQ,
  parameter int unsigned num_slv        = NUM_SLV,
  parameter int unsigned timeout_cycles = 1024,
  parameter int unsigned cnt_width      = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [num_req-1:0]          req_valid,
  input  logic [num_req-1:0][31:0]    req_addr,
  input  logic [num_req-1:0][31:0]    req_wdata,
  input  logic [num_req-1:0][3:0]     req_wstrb,
  output logic [num_req-1:0]          req_ready,
  output logic [31:0]                 req_rdata,
  output logic                        req_error,
  output logic [num_slv-1:0]          slv_valid,
  output logic [31:0]                 slv_addr,
  output logic [31:0]                 slv_wdata,
  output logic [3:0]                  slv_wstrb,
  input  logic [num_slv-1:0]          slv_ready,
  input  logic [num_slv-1:0][31:0]    slv_rdata
);

  arb_state_e             state_q, state_d;
  logic                   port_q, port_d;
  logic                   rr_last_q, rr_last_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [cnt_width-1:0]   cnt_q, cnt_d;

  logic                   gnt;
  logic [31:0]            gnt_addr;
  logic [num_slv-1:0]     hit;
  logic                   unmapped;
  logic [IDX_W-1:0]       hit_idx;

  // On a tie the port that did not win last time is granted
  assign gnt      = (&req_valid) ? ~rr_last_q : req_valid[1];
  assign gnt_addr = req_addr[gnt];

  periph_addr_decode u_decode (
    .addr     (gnt_addr),
    .hit      (hit),
    .unmapped (unmapped)
  );

  always_comb begin
    hit_idx = '0;
    for (int unsigned k = 0; k < num_slv; k++) begin
      if (hit[k]) hit_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      rr_last_q <= 1'b1;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      rr_last_q <= rr_last_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    rr_last_d = rr_last_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          port_d    = gnt;
          rr_last_d = gnt;
          cnt_d     = '0;
          if (unmapped) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            idx_d   = hit_idx;
            addr_d  = gnt_addr;
            wdata_d = req_wdata[gnt];
            wstrb_d = req_wstrb[gnt];
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (slv_ready[idx_q]) begin
          rdata_d = slv_rdata[idx_q];
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == cnt_width'(timeout_cycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slv_valid = '0;
    slv_addr  = '0;
    slv_wdata = '0;
    slv_wstrb = '0;
    req_ready = '0;
    req_rdata = '0;
    req_error = 1'b0;
    if (state_q == ACCESS) begin
      slv_valid[idx_q] = 1'b1;
      slv_addr         = addr_q;
      slv_wdata        = wdata_q;
      slv_wstrb        = wstrb_q;
    end
    if (state_q == RESP) begin
      req_ready[port_q] = 1'b1;
      req_rdata         = rdata_q;
      req_error         = err_q;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: scoreboarded responses, a
// latency-programmable slave model and scenario tasks.
module tb_periph_bus_arbiter;
  import periph_bus_arbiter_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_wstrb;
  logic [1:0]       req_ready;
  logic [31:0]      req_rdata;
  logic             req_error;
  logic [4:0]       slv_valid;
  logic [31:0]      slv_addr;
  logic [31:0]      slv_wdata;
  logic [3:0]       slv_wstrb;
  logic [4:0]       rdy_model = '0;
  logic [4:0]       rdy_inject = '0;
  logic [4:0][31:0] sdata;

  int               lat [5];
  int               acc_cnt = 0;
  int               vcnt [5] = '{default: 0};
  logic [31:0]      last_addr = '0;
  logic [31:0]      last_wdata = '0;
  logic [3:0]       last_wstrb = '0;

  typedef struct {
    logic [1:0]  ready;
    logic [31:0] rdata;
    logic        error;
  } resp_t;
  resp_t sb[$];

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  periph_bus_arbiter #(
    .num_req        (2),
    .num_slv        (5),
    .timeout_cycles (1024),
    .cnt_width      (10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .req_error (req_error),
    .slv_valid (slv_valid),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_wstrb (slv_wstrb),
    .slv_ready (rdy_model | rdy_inject),
    .slv_rdata (sdata)
  );

  // Slave model: answers lat[k] cycles into an access (lat < 0 never answers)
  always @(posedge clock) begin
    #1;
    rdy_model = '0;
    if (slv_valid == '0) acc_cnt = 0;
    else begin
      for (int k = 0; k < 5; k++)
        if (slv_valid[k] && lat[k] == acc_cnt) rdy_model[k] = 1'b1;
      acc_cnt++;
    end
  end

  always @(posedge clock) begin
    #3;
    for (int k = 0; k < 5; k++) if (slv_valid[k]) vcnt[k]++;
    if (slv_valid != '0) begin
      last_addr  = slv_addr;
      last_wdata = slv_wdata;
      last_wstrb = slv_wstrb;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc, output int cyc, output bit got, output bit dirty);
    cyc = 0; got = 0; dirty = 0;
    while (!got && cyc < max_cyc) begin
      @(negedge clock);
      cyc++;
      if (req_ready != 2'b00) got = 1;
      else if (req_rdata !== '0 || req_error !== 1'b0) dirty = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    @(negedge clock);
    total++;
    if ({req_ready, req_rdata, req_error, slv_valid, slv_addr, slv_wdata, slv_wstrb} !== '0)
      $display("FAIL reset_outputs: ready=%b rdata=%h err=%b slv_valid=%b addr=%h wdata=%h wstrb=%h required all 0",
               req_ready, req_rdata, req_error, slv_valid, slv_addr, slv_wdata, slv_wstrb);
    else passed++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_clint_read();
    int cyc; bit got, dirty; int v0; resp_t e;
    lat[SLV_CLINT] = 0; sdata[SLV_CLINT] = 32'hDEAD_BEEF;
    sb.push_back('{2'b10, 32'hDEAD_BEEF, 1'b0});
    v0 = vcnt[SLV_CLINT];
    step();
    req_valid[1] = 1'b1; req_addr[1] = 32'h0200_0004; req_wstrb[1] = 4'h0;
    wait_ready(10, cyc, got, dirty);
    req_valid[1] = 1'b0;
    e = sb.pop_front();
    total++;
    if (!got || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
      $display("FAIL clint_resp: got=%0b ready=%b rdata=%h err=%b required ready=%b rdata=%h err=%b",
               got, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
    else passed++;
    total++;
    if (cyc !== 3) $display("FAIL clint_latency: %0d cycles required 3", cyc); else passed++;
    total++;
    if (vcnt[SLV_CLINT] - v0 !== 1 || last_addr !== 32'h0200_0004)
      $display("FAIL clint_select: valid cycles %0d addr %h required 1 / 02000004",
               vcnt[SLV_CLINT] - v0, last_addr);
    else passed++;
    total++;
    if (dirty) $display("FAIL clint_idle_zero: rdata/error nonzero without ready, required 0"); else passed++;
  endtask

  task automatic test_tie_rr();
    int cyc; bit got, dirty; resp_t e;
    lat[SLV_RAM] = 1; sdata[SLV_RAM] = 32'h5A5A_0004;
    lat[SLV_ROM] = 0; sdata[SLV_ROM] = 32'h5A5A_0000;
    lat[SLV_UART] = 0; sdata[SLV_UART] = 32'h5A5A_0002;
    sb.push_back('{2'b01, 32'h5A5A_0004, 1'b0});
    sb.push_back('{2'b10, 32'h5A5A_0000, 1'b0});
    sb.push_back('{2'b01, 32'h5A5A_0000, 1'b0});
    sb.push_back('{2'b10, 32'h5A5A_0002, 1'b0});
    for (int pair = 0; pair < 2; pair++) begin
      step();
      req_valid = 2'b11;
      req_addr[0] = (pair == 0) ? 32'h8000_0000 : 32'h0000_0000;
      req_addr[1] = (pair == 0) ? 32'h0000_0010 : 32'h0100_0004;
      req_wstrb = '0;
      for (int n = 0; n < 2; n++) begin
        wait_ready(10, cyc, got, dirty);
        e = sb.pop_front();
        total++;
        if (!got || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
          $display("FAIL tie_rr_p%0d_r%0d: got=%0b ready=%b rdata=%h err=%b required ready=%b rdata=%h err=%b",
                   pair, n, got, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
        else passed++;
        req_valid = req_valid & ~e.ready;
      end
      req_valid = '0;
    end
  endtask

  task automatic test_unmapped();
    int cyc; bit got, dirty; int vsum0, vsum1; resp_t e;
    vsum0 = vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] + vcnt[4];
    sb.push_back('{2'b10, 32'h0, 1'b1});
    step();
    req_valid[1] = 1'b1; req_addr[1] = 32'h4000_0000;
    req_wdata[1] = 32'hCAFE_F00D; req_wstrb[1] = 4'hF;
    wait_ready(10, cyc, got, dirty);
    req_valid[1] = 1'b0;
    e = sb.pop_front();
    total++;
    if (!got || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
      $display("FAIL unmapped_resp: got=%0b ready=%b rdata=%h err=%b required ready=%b rdata=%h err=%b",
               got, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
    else passed++;
    total++;
    if (cyc !== 2) $display("FAIL unmapped_latency: %0d cycles required 2", cyc); else passed++;
    repeat (2) step();
    vsum1 = vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] + vcnt[4];
    total++;
    if (vsum1 !== vsum0) $display("FAIL unmapped_no_slave: %0d select cycles required 0", vsum1 - vsum0);
    else passed++;
  endtask

  task automatic test_timeout();
    int cyc; bit got, dirty, stray; int v0; resp_t e;
    lat[SLV_SPI] = -1; sdata[SLV_SPI] = 32'h0BAD_0BAD;
    v0 = vcnt[SLV_SPI];
    sb.push_back('{2'b01, 32'h0, 1'b1});
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0010_0040; req_wstrb[0] = 4'h0;
    wait_ready(1100, cyc, got, dirty);
    req_valid[0] = 1'b0;
    e = sb.pop_front();
    total++;
    if (!got || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
      $display("FAIL timeout_resp: got=%0b ready=%b rdata=%h err=%b required ready=%b rdata=%h err=%b",
               got, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
    else passed++;
    total++;
    if (vcnt[SLV_SPI] - v0 !== 1024)
      $display("FAIL timeout_hold: slv_valid[1] high %0d cycles required 1024", vcnt[SLV_SPI] - v0);
    else passed++;
    repeat (5) step();
    rdy_inject[SLV_SPI] = 1'b1;
    step();
    rdy_inject = '0;
    stray = 0;
    repeat (5) begin
      @(negedge clock);
      if (req_ready != '0 || slv_valid != '0) stray = 1;
    end
    total++;
    if (stray) $display("FAIL late_ready: response or select seen after late slv_ready, required none");
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit got, dirty, stray; resp_t e;
    lat[SLV_UART] = -1;
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0100_0008; req_wstrb[0] = 4'h0;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clock);
      if (slv_valid[SLV_UART]) got = 1;
    end
    total++;
    if (!got) $display("FAIL reset_mid_select: slv_valid=%b required uart selected", slv_valid); else passed++;
    step();
    reset = 1'b1; req_valid = '0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({req_ready, req_rdata, req_error, slv_valid, slv_addr, slv_wdata, slv_wstrb} !== '0)
      $display("FAIL reset_mid_outputs: ready=%b slv_valid=%b addr=%h required all 0", req_ready, slv_valid, slv_addr);
    else passed++;
    reset = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      if (req_ready != '0) stray = 1;
    end
    total++;
    if (stray) $display("FAIL reset_mid_silent: req_ready seen after abort, required none"); else passed++;
    lat[SLV_UART] = 2; sdata[SLV_UART] = 32'h0000_0055;
    sb.push_back('{2'b01, 32'h0000_0055, 1'b0});
    step();
    req_valid[0] = 1'b1;
    wait_ready(20, cyc, got, dirty);
    req_valid[0] = 1'b0;
    e = sb.pop_front();
    total++;
    if (!got || cyc !== 5 || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
      $display("FAIL reset_mid_recover: got=%0b cycles=%0d ready=%b rdata=%h err=%b required 5 cycles ready=%b rdata=%h err=%b",
               got, cyc, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
    else passed++;
  endtask

  task automatic test_alternate();
    int cyc; bit got, dirty; resp_t e;
    reset = 1'b1;
    step();
    reset = 1'b0;
    lat[SLV_ROM] = 0; sdata[SLV_ROM] = 32'h1111_0000;
    lat[SLV_RAM] = 0; sdata[SLV_RAM] = 32'h2222_0004;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{2'b01, 32'h1111_0000, 1'b0});
      sb.push_back('{2'b10, 32'h2222_0004, 1'b0});
    end
    req_addr[0] = 32'h0000_0020; req_wstrb[0] = 4'h0;
    req_addr[1] = 32'h8000_0040; req_wdata[1] = 32'h1234_5678; req_wstrb[1] = 4'h3;
    req_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      wait_ready(10, cyc, got, dirty);
      e = sb.pop_front();
      total++;
      if (!got || req_ready !== e.ready || req_rdata !== e.rdata || req_error !== e.error)
        $display("FAIL alternate_%0d: got=%0b ready=%b rdata=%h err=%b required ready=%b rdata=%h err=%b",
                 n, got, req_ready, req_rdata, req_error, e.ready, e.rdata, e.error);
      else passed++;
      if (n == 5) req_valid = '0;
    end
    total++;
    if (last_addr !== 32'h8000_0040 || last_wdata !== 32'h1234_5678 || last_wstrb !== 4'h3)
      $display("FAIL write_fields: addr=%h wdata=%h wstrb=%h required 80000040/12345678/3",
               last_addr, last_wdata, last_wstrb);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    sdata = '0;
    for (int k = 0; k < 5; k++) lat[k] = 0;
    test_reset();
    test_clint_read();
    test_tie_rr();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_alternate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the core's uncached peripheral/memory bus between two requesters: instruction fetch (port 0) and data access (port 1).
- Decodes the granted address against the system memory map: rom, spi, uart (tx+rx), clint, ram.
- Drives exactly one slave select, returns the response to the winning requester, and generates error responses for unmapped addresses and slave timeouts.
- Sits between the core's fetch/load-store units and the peripheral fabric; itim/dtim are core-local and never routed here.

Parameters:
- num_req, 2, number of requesters (fixed; port 0 = fetch, port 1 = data)
- num_slv, 5, number of slaves (0 rom, 1 spi, 2 uart, 3 clint, 4 ram)
- timeout_cycles, 1024, maximum cycles a slave may hold an access before an error is forced
- cnt_width, 10, width of the timeout counter; must satisfy 2**cnt_width >= timeout_cycles

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  request valid per requester; held until that requester's req_ready
- req_addr  in  2x32  request address per requester
- req_wdata  in  2x32  write data per requester
- req_wstrb  in  2x4  byte strobes per requester; 0 = read
- req_ready  out  2  one-cycle response pulse per requester
- req_rdata  out  32  read data, valid with req_ready
- req_error  out  1  error flag, valid with req_ready
- slv_valid  out  5  one-hot slave select; held for the whole access
- slv_addr  out  32  granted address
- slv_wdata  out  32  granted write data
- slv_wstrb  out  4  granted strobes
- slv_ready  in  5  per-slave completion pulse
- slv_rdata  in  5x32  per-slave read data

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last = 1, so port 0 wins the first tie; timeout counter 0. A reset mid-access aborts the access silently and produces no response.
- Address decode: slave k hits when (addr & ~mask_k) == base_k.
  - rom: base 0x0, mask 0x7F
  - spi: base 0x100000, mask 0xFFFFF
  - uart: base 0x1000000, mask 0x1F
  - clint: base 0x2000000, mask 0xFFFF
  - ram: base 0x80000000, mask 0xFFFFF
  - Evaluate in index order; the first hit wins. No hit = unmapped.
- Arbitration happens in IDLE only. With one requester valid, grant it. With both valid, grant the one not equal to rr_last. rr_last is updated on every grant.
- States:
  - IDLE:
    - No valid request: stay in IDLE.
    - Granted address mapped: latch port index, slave index, addr, wdata and wstrb; go to ACCESS. slv_valid[k] rises at the next clock edge, i.e. 1 cycle after the request is sampled.
    - Granted address unmapped: go to RESP with error=1, rdata=0. No slave is touched.
  - ACCESS:
    - slv_valid[k] is held and the counter increments each cycle.
    - slv_ready[k]=1: capture slv_rdata[k], error=0, drop slv_valid, go to RESP.
    - Counter reaches timeout_cycles-1 without slv_ready[k]: drop slv_valid, error=1, rdata=0, go to RESP.
    - slv_ready on non-selected slaves is ignored.
  - RESP:
    - Assert req_ready[granted] for exactly 1 cycle, with req_rdata and req_error.
    - Return to IDLE; clear the counter.
    - req_valid is not sampled in RESP, so the requester has this cycle to deassert.
- Latency:
  - Mapped access: slave sees slv_valid 1 cycle after request; requester sees req_ready 1 cycle after slv_ready. A slave answering in its first cycle gives 3 cycles request-to-ready.
  - Unmapped access: 2 cycles request-to-ready.
  - Back-to-back: the next grant occurs in the IDLE cycle after RESP.
- Only one transaction is outstanding globally. The non-granted requester waits with valid held.
- A late slv_ready arriving in IDLE after a timeout is ignored.
- req_rdata and req_error are 0 whenever req_ready is 0.

Decomposition:
- Shared package (alongside the system configuration package):
  - slave index constants
  - state enum (IDLE, ACCESS, RESP)
  - base/mask arrays built from the system address constants
  - uart base/mask merged to 0x1000000 / 0x1F
- One sub-module, periph_addr_decode: combinational, taking a 32-bit address and producing a 5-bit one-hot hit plus an unmapped flag. Used on the arbitration path.

Test Plan:
- Port 1 reads 0x02000004; clint asserts slv_ready on the first ACCESS cycle with rdata 0xDEADBEEF -> slv_valid=5'b01000 for 1 cycle; req_ready[1] 3 cycles after the request with rdata 0xDEADBEEF, error 0.
- Both ports valid in the same cycle after reset (port 0 addr 0x80000000, port 1 addr 0x00000010) -> port 0 served first on ram, then port 1 served on rom; a further simultaneous pair goes to port 0 again (round-robin, rr_last=1 after the port 1 grant).
- Port 1 writes 0x40000000 with wstrb 0xF -> no slv_valid ever asserted; req_ready[1] after 2 cycles with error 1, rdata 0.
- spi selected and never readies -> slv_valid[1] high for exactly 1024 cycles, then req_ready with error 1; a slv_ready[1] pulse 5 cycles later is ignored.
- Reset asserted for 1 cycle during ACCESS to uart -> all outputs 0 next cycle, no req_ready; a subsequent request completes normally.
- Port 0 holds valid continuously while port 1 issues 3 requests -> grants strictly alternate 0,1,0,1,0,1; neither port is starved.
